// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: FSM states,
// queue entry layout and instruction width.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ENTRY_PC_W = 6;
    localparam int ENTRY_ROBID_W = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_BR = 2'd1,
        HALTED  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0]       instr;
        logic [ENTRY_ROBID_W-1:0] robid;
        logic [ENTRY_PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two ring buffer of fetch_entry_t.
// flush_younger drops everything behind the head; head goes too if popped.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush_younger,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;

    assign head  = mem[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (push && !flush_younger) begin
            mem[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            unique case (1'b1)
                flush_younger && pop: begin
                    rd_q  <= '0;
                    wr_q  <= '0;
                    cnt_q <= '0;
                end
                flush_younger && !pop: begin
                    wr_q  <= empty ? rd_q : rd_q + AW'(1);
                    cnt_q <= empty ? '0 : CW'(1);
                end
                !flush_younger: begin
                    if (push) wr_q <= wr_q + AW'(1);
                    if (pop)  rd_q <= rd_q + AW'(1);
                    cnt_q <= cnt_q + CW'(push) - CW'(pop);
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC and ROB-id allocation, credit throttling,
// branch serialisation and halt, feeding the decoder from fetch_fifo.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = ENTRY_PC_W,
    parameter int ROBID_W = ENTRY_ROBID_W,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [15:0]        rom_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_instr,
    output logic [ROBID_W-1:0] out_robid,
    output logic [PC_W-1:0]    out_pc,
    input  logic               serialize,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic               redirect_not_taken,
    input  logic [7:0]         redirect_pc,
    input  logic               retire_valid,
    output logic [ROBID_W:0]   inflight,
    output logic [1:0]         state_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = ROBID_W + 1;
    localparam logic [IW-1:0] LIMIT = IW'(2 ** ROBID_W);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [ROBID_W-1:0] robid_q, robid_d;
    logic [IW-1:0]      infl_q, infl_d, infl_eff;

    fetch_entry_t  head, push_data;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          running, pop, flush, push;
    logic [CW-1:0] flushed;

    assign running   = (state_q == RUN);
    assign out_valid = running && !empty;
    assign pop       = out_valid && out_ready;
    assign flush     = pop && (serialize || halt);

    // A same-cycle retire frees its credit before the push check.
    assign infl_eff = (retire_valid && infl_q != '0) ? infl_q - IW'(1) : infl_q;
    assign push     = running && !flush && (!full || pop) && (infl_eff < LIMIT);
    assign flushed  = flush ? count - CW'(1) : '0;
    assign infl_d   = infl_eff + IW'(push) - IW'(flushed);

    assign push_data = '{instr: rom_data, robid: robid_q, pc: pc_q};

    assign out_instr = empty ? '0 : head.instr;
    assign out_robid = empty ? '0 : head.robid;
    assign out_pc    = empty ? '0 : head.pc;
    assign rom_addr  = pc_q;
    assign inflight  = infl_q;
    assign state_o   = state_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, redirect_pc[7:PC_W]};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .flush_younger(flush),
        .head         (head),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        robid_d = robid_q;
        unique case (state_q)
            RUN: begin
                if (push) begin
                    pc_d    = pc_q + PC_W'(1);
                    robid_d = robid_q + ROBID_W'(1);
                end
                // Rewind to just past the branch; wrong-path words are gone.
                if (flush) begin
                    pc_d    = out_pc + PC_W'(1);
                    robid_d = out_robid + ROBID_W'(1);
                    state_d = halt ? HALTED : WAIT_BR;
                end
            end
            WAIT_BR: begin
                if (redirect_valid) begin
                    if (!redirect_not_taken) pc_d = redirect_pc[PC_W-1:0];
                    state_d = RUN;
                end
            end
            HALTED: ;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            robid_q <= '0;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            robid_q <= robid_d;
            infl_q  <= infl_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end fetch stage: owns the PC and ROB-id allocation, and drives the instruction ROM address.
- Buffers fetched words in a small FIFO that feeds the decoder through a valid/ready handshake.
- Serialises on branches: flushes wrong-path words and waits for the ROB branch resolution.
- Stops permanently on halt, and throttles fetch so no more than 2^ROBID_W instructions are in flight un-retired.

Parameters:
PC_W, 6, program counter / ROM address width
ROBID_W, 4, ROB tag width; in-flight limit = 2^ROBID_W
DEPTH, 4, fetch-queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rom_addr  out  PC_W  instruction ROM address (= pc register)
rom_data  in  16  combinational ROM word for rom_addr
out_valid  out  1  queue head valid to decoder
out_ready  in  1  decoder accepts head this cycle
out_instr  out  16  head instruction word
out_robid  out  ROBID_W  head ROB tag
out_pc  out  PC_W  head PC
serialize  in  1  decoder: accepted head is a branch; stop and flush younger
halt  in  1  decoder: accepted head is HALT
redirect_valid  in  1  ROB branch resolution (single-cycle pulse)
redirect_not_taken  in  1  qualifies redirect_valid
redirect_pc  in  8  branch target; low PC_W bits used
retire_valid  in  1  ROB retired one instruction (returns one credit)
inflight  out  ROBID_W+1  allocated, un-retired count
state_o  out  2  FSM state for debug

Behaviour:
- Reset values: pc=0, next robid=0, queue empty, out_valid=0, inflight=0, state=RUN. Outputs out_instr, out_robid and out_pc read 0 when empty.
- FSM states: RUN=0, WAIT_BR=1, HALTED=2.
- RUN push condition: (queue not full OR head popped this cycle) AND inflight < 2^ROBID_W (counting the same-cycle retire).
- RUN push action:
  - Enqueue {rom_data, robid, pc}.
  - pc <= pc+1, wrapping 2^PC_W-1 -> 0.
  - robid <= robid+1, wrapping mod 2^ROBID_W.
  - inflight increments.
- Pop: out_valid & out_ready; head leaves the same cycle. Fetch latency is 1 cycle: a word fetched at edge N is presentable at out_valid after edge N.
- Full queue with simultaneous pop: push is allowed. Empty queue: out_valid=0 and pop is impossible.
- serialize is sampled only with a pop:
  - Flush every entry behind the popped head, plus the word being pushed this cycle.
  - pc <= out_pc+1 and robid <= out_robid+1.
  - inflight -= number of flushed entries (the popped branch keeps its credit).
  - state <= WAIT_BR.
- WAIT_BR: no push; out_valid=0.
  - On redirect_valid with redirect_not_taken=0: pc <= redirect_pc[PC_W-1:0].
  - On redirect_valid with redirect_not_taken=1: pc is unchanged (already rewound).
  - Either case: state <= RUN; fetch resumes the following cycle.
- halt is sampled only with a pop: flush the same way as serialize, then state <= HALTED. HALTED holds until rst; out_valid=0 and no push.
- redirect_valid outside WAIT_BR is ignored. serialize and halt both set in one pop: halt wins.
- retire_valid in any state decrements inflight, saturating at 0. Retire, push and flush in the same cycle combine arithmetically: inflight' = inflight + push - retire - flushed.
- rst mid-operation: all state returns to reset values on the next edge, regardless of FSM state.

Decomposition:
- fetch_pkg: fetch_state_t enum (RUN, WAIT_BR, HALTED); fetch_entry_t struct {instr, robid, pc}; INSTR_W=16 constant.
- Sub-module fetch_fifo:
  - Parameterised DEPTH, carrying fetch_entry_t.
  - Interface: push/pop/flush_younger ports; count, full, empty outputs.
  - Flush keeps or drops the head depending on whether it is popped.
- fetch_unit holds the FSM, PC, robid counters and credit counter.

Test Plan:
1. Reset, ROM[i]=16'h0100+i, out_ready=1 -> out_pc 0,1,2,… on consecutive cycles with out_robid = out_pc mod 16; out_valid first high 1 cycle after reset release.
2. out_ready=0 for 10 cycles -> queue fills to 4, rom_addr holds at 4, inflight=4; release -> PCs 0..3 drain in order with no loss or duplication.
3. Pop pc=5/robid=5 with serialize while queue holds 6,7,8 -> flushed, inflight=6, state=WAIT_BR; redirect taken to 8'h20 -> next out_pc=32, out_robid=6. Repeat with not-taken -> next out_pc=6.
4. No retires, out_ready=1 -> exactly 16 pushes, then fetch stops with inflight=16; one retire_valid pulse -> exactly one more push, with robid wrapping 15->0.
5. Pop with halt=1 -> state=HALTED, out_valid stays 0 for 20 cycles despite a redirect pulse; rst -> pc=0, inflight=0, state=RUN.
6. pc=63 fetch -> next rom_addr=0; serialize and halt asserted together -> HALTED.
